// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
//   uart_state_t : frame-level FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/ODD : meaning of the parity-type control bit
//   parity_bit() : turns the XOR-reduction of a data word into the line parity bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Even parity: bit equals the XOR of the data, so the total count of ones
    // (data + parity) is even. Odd parity is its inverse.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register plus bit counter for the UART transmitter data phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data and restart the bit counter at 0
//   load_data  : parallel word to serialize
//   shift      : move to the next data bit (shift right, count up)
//   head_bit   : bit currently at the LSB end of the shift register
//   next_bit   : the bit that becomes head after the next shift
//   done       : the counter is at the last data bit (Data_Width-1)
// Data_Width must be at least 2.
module uart_tx_serializer #(
    parameter int Data_Width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [Data_Width-1:0] load_data,
    input  logic                  shift,
    output logic                  head_bit,
    output logic                  next_bit,
    output logic                  done
);

    localparam int CNT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;

    logic [Data_Width-1:0] shift_reg;
    logic [CNT_W-1:0]      cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            cnt_reg   <= '0;
        end else if (shift) begin
            shift_reg <= {1'b0, shift_reg[Data_Width-1:1]};
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign head_bit = shift_reg[0];
    // The line output is registered, so the FSM needs the bit one step ahead.
    assign next_bit = shift_reg[1];
    assign done     = (cnt_reg == CNT_W'(Data_Width - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per CLK cycle (clock already baud-divided).
// Frame: start(0), Data_Width data bits LSB first, optional parity, stop(1).
//   CLK        : bit clock
//   RST        : asynchronous active-low reset
//   P_Data     : parallel word to send
//   Data_Valid : single-cycle request, honoured only while idle
//   PAR_EN     : 1 = append parity bit
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   TX_OUT     : registered serial line, idle high
//   Busy       : registered, high from start bit through stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_Width-1:0] P_Data,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    uart_state_t           state_reg, state_next;
    logic [Data_Width-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic                  tx_out_reg, tx_next;
    logic                  busy_reg, busy_next;

    logic                  load;
    logic                  shift;
    logic                  head_bit;
    logic                  next_bit;
    logic                  done;

    uart_tx_serializer #(
        .Data_Width (Data_Width)
    ) u_serializer (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (load),
        .load_data (P_Data),
        .shift     (shift),
        .head_bit  (head_bit),
        .next_bit  (next_bit),
        .done      (done)
    );

    // Outputs are registered, so tx_next/busy_next describe what the line
    // must show in the state being entered, not the current one.
    always_comb begin
        state_next = state_reg;
        tx_next    = 1'b1;
        busy_next  = 1'b1;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (Data_Valid) begin
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    load       = 1'b1;
                end
            end
            START: begin
                state_next = DATA;
                tx_next    = head_bit;
            end
            DATA: begin
                if (!done) begin
                    shift   = 1'b1;
                    tx_next = next_bit;
                end else if (par_en_reg) begin
                    state_next = PARITY;
                    // Parity comes from the latched word, never live P_Data.
                    tx_next    = parity_bit(^data_reg, par_typ_reg);
                end else begin
                    state_next = STOP;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
                // Returning to IDLE guarantees one idle cycle between frames;
                // a request seen during STOP is simply not looked at.
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            tx_out_reg  <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tx_out_reg <= tx_next;
            busy_reg   <= busy_next;
            if (load) begin
                data_reg    <= P_Data;
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
            end
        end
    end

    assign TX_OUT = tx_out_reg;
    assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. A frame-level reference model turns each accepted
// request into the list of line bits it must produce and queues them; a
// monitor compares TX_OUT/Busy against that queue every cycle (idle-high,
// not busy when the queue is empty).
module tb_uart_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] P_Data = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         Busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;
    int cyc      = 0;

    logic exp_q[$];     // expected line bits still to appear (Busy=1 for each)
    int   remaining = 0; // clock edges until the model is idle again

    uart_tx #(.Data_Width(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_Data     (P_Data),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Monitor: one comparison per cycle, away from the active edge.
    always @(negedge CLK) begin
        logic exp_tx;
        logic exp_busy;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end
        n_checks = n_checks + 1;
        if (TX_OUT !== exp_tx || Busy !== exp_busy) begin
            n_errors = n_errors + 1;
            $display("FAIL line cyc=%0d: got TX_OUT=%b Busy=%b, expected TX_OUT=%b Busy=%b",
                     cyc, TX_OUT, Busy, exp_tx, exp_busy);
        end
    end

    // Reference model, evaluated at every rising edge with the inputs the DUT saw.
    task automatic model_edge();
        logic [W-1:0] d;
        logic         par;
        int           len;
        if (!RST) begin
            remaining = 0;
        end else if (remaining == 0 && Data_Valid) begin
            d   = P_Data;
            par = logic'($countones(d) % 2) ^ PAR_TYP;
            exp_q.push_back(1'b0);
            for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
            if (PAR_EN) exp_q.push_back(par);
            exp_q.push_back(1'b1);
            len = W + 2 + (PAR_EN ? 1 : 0);
            remaining = len;
            n_frames = n_frames + 1;
            $display("frame %0d: data=0x%02h par_en=%b par_typ=%b len=%0d", n_frames, d, PAR_EN, PAR_TYP, len);
        end else if (remaining > 0) begin
            remaining = remaining - 1;
        end
    endtask

    task automatic cycle(input logic dv, input logic [W-1:0] d, input logic pe, input logic pt);
        Data_Valid = dv;
        P_Data     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        // Reset held for a few cycles: monitor checks idle line meanwhile.
        idle(3);
        #2 RST = 1'b1;
        idle(3);

        // 0xA5, no parity.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(12);
        // 0x07 even parity, then odd parity.
        cycle(1'b1, 8'h07, 1'b1, 1'b0);
        idle(13);
        cycle(1'b1, 8'h07, 1'b1, 1'b1);
        idle(13);

        // Request with 0xFF during DATA of a 0xA5 frame must be ignored.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 8'hFF, 1'b1, 1'b1);
        idle(14);

        // Data_Valid held high: back-to-back frames with one idle cycle.
        for (int i = 0; i < 40; i++) cycle(1'b1, W'($urandom), 1'($urandom), 1'($urandom));
        idle(14);

        // Reset asserted during the 4th data bit.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(4);
        #2 RST = 1'b0;
        exp_q.delete();
        remaining = 0;
        #1;
        n_checks = n_checks + 1;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_errors = n_errors + 1;
            $display("FAIL reset_abort: got TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
        idle(2);
        RST = 1'b1;
        idle(6);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        idle(13);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom), 1'($urandom));
        idle(14);

        // Every queued bit must have been consumed.
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL drain: got %0d bits pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
